seven_seg_scanner: RTL and testbench

//  Time-multiplexed driver for a multi-digit common-anode/cathode 7-segment display.

---
 rtl/seven_seg_if.sv | 23 ++
 rtl/seven_seg_scanner.sv | 133 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// Bundle of data, control and display signals between a digit source and the scanner.
interface seven_seg_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output digits, dp_in, load, lz_blank,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits, dp_in, load, lz_blank,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scanner: one digit per refresh slot, dead time at slot start,
// leading-zero blanking and double-buffered digits that only swap at frame boundaries.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 100_000,
  parameter int unsigned BLANK_CYCLES  = 1_000,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input logic       clk,
  input logic       rst,
  seven_seg_if.slave bus
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AnOff = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CntW-1:0]                 slot_cnt_q;
  logic [IdxW-1:0]                 idx_q;
  logic [NUM_DIGITS-1:0][3:0]      pend_q;
  logic [NUM_DIGITS-1:0]           pend_dp_q;
  logic                            pend_valid_q;
  logic [NUM_DIGITS-1:0][3:0]      disp_q;
  logic [NUM_DIGITS-1:0]           disp_dp_q;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic                            frame_done_q;

  logic                            slot_wrap;
  logic                            frame_end;
  logic [NUM_DIGITS-1:0]           blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign slot_wrap = (slot_cnt_q == CntW'(REFRESH_DIV - 1));
  assign frame_end = slot_wrap && (idx_q == IdxW'(NUM_DIGITS - 1));

  // A digit is blanked when it and every more-significant digit are zero; digit 0 never is.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_q[k] == 4'd0);
      blank[k]   = bus.lz_blank && zero_above;
    end
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = AnOff;
    if (slot_cnt_q >= CntW'(BLANK_CYCLES)) begin
      an_d  = AnOff ^ (NUM_DIGITS'(1) << idx_q);
      seg_d = blank[idx_q] ? 7'b0000000 : decode(disp_q[idx_q]);
      dp_d  = disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      slot_cnt_q <= slot_wrap ? '0 : slot_cnt_q + CntW'(1);
      if (frame_end) begin
        idx_q <= '0;
      end else if (slot_wrap) begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  // The display buffer is only written at a frame boundary, so a frame never tears.
  // A load in the boundary cycle lands in pending and waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
    end else begin
      if (frame_end && pend_valid_q) begin
        disp_q       <= pend_q;
        disp_dp_q    <= pend_dp_q;
        pend_valid_q <= 1'b0;
      end
      if (bus.load) begin
        pend_q       <= bus.digits;
        pend_dp_q    <= bus.dp_in;
        pend_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= AnOff;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_end;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random loads, checked every cycle
// against a cycle-count based model of the scan and the frame-buffered digits.
module tb_seven_seg_scanner;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned BLK = 2;
  localparam int unsigned FRAME = ND * DIV;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seven_seg_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: e = clock edges since reset release.
  int          e;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv;
  logic [6:0]  seg_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e      = 0;
    m_disp = '0;
    m_pend = '0;
    m_ddp  = '0;
    m_pdp  = '0;
    m_pv   = 1'b0;
  endtask

  // One clock: predict outputs from the scan position held before the edge, then compare.
  task automatic step();
    int         slot;
    int         idx;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    logic       x_fd;
    logic [3:0] d;
    bit         blanked;
    slot  = e % DIV;
    idx   = (e / DIV) % ND;
    x_an  = 4'hF;
    x_seg = '0;
    x_dp  = 1'b0;
    if (slot >= BLK) begin
      x_an    = 4'hF & ~(4'b0001 << idx);
      d       = m_disp[4*idx +: 4];
      blanked = bus.lz_blank && (idx != 0) && ((m_disp >> (4 * idx)) == 16'd0);
      x_seg   = blanked ? 7'b0 : seg_tab[d];
      x_dp    = m_ddp[idx];
    end
    x_fd = (e % FRAME) == (FRAME - 1);
    if (x_fd && m_pv) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
      m_pv   = 1'b0;
    end
    if (bus.load) begin
      m_pend = bus.digits;
      m_pdp  = bus.dp_in;
      m_pv   = 1'b1;
    end
    e++;
    @(posedge clk);
    #1;
    check("an", {28'd0, bus.an}, {28'd0, x_an});
    check("seg", {25'd0, bus.seg}, {25'd0, x_seg});
    check("dp", {31'd0, bus.dp}, {31'd0, x_dp});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, x_fd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.digits = d;
    bus.dp_in  = p;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < FRAME && (e % FRAME) != pos; i++) step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fd_edges[$];
    int          f0;
    int          f1;
    bit          seen_one;
    bit          seen_two;
    logic [15:0] rd;
    int          nz;

    checks   = 0;
    failures = 0;
    seg_tab  = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b0, 7'b0, 7'b0, 7'b0,
                 7'b0, 7'b0};
    bus.digits   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
    rst          = 1'b1;
    model_reset();

    // Reset held: everything inactive.
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_seg", {25'd0, bus.seg}, 32'h0);
    check("rst_dp", {31'd0, bus.dp}, 32'h0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'h0);
    rst = 1'b0;
    model_reset();

    // First lit output on the third edge after release.
    run(3);
    check("first_lit_an", {28'd0, bus.an}, 32'hE);
    check("first_lit_seg", {25'd0, bus.seg}, {25'd0, 7'b1111110});
    run(FRAME);

    // Plain digits.
    do_load(16'h1234, 4'b0000);
    run(2 * FRAME);

    // Leading-zero blanking.
    bus.lz_blank = 1'b1;
    do_load(16'h0045, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);

    // Two loads in one frame: only the later one is ever shown.
    align(2);
    do_load(16'h1111, 4'b0000);
    run(10);
    do_load(16'h2222, 4'b0000);
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.seg == 7'b0110000) seen_one = 1'b1;
      if (bus.seg == 7'b1101101) seen_two = 1'b1;
    end
    check("never_show_ones", {31'd0, seen_one}, 32'd0);
    check("shows_twos", {31'd0, seen_two}, 32'd1);

    // Non-BCD codes and decimal points.
    do_load(16'hA5F9, 4'b0100);
    run(2 * FRAME);

    // Load exactly in the boundary cycle.
    align(FRAME - 2);
    do_load(16'h5678, 4'b1001);
    do_load(16'h9876, 4'b0110);
    run(2 * FRAME);

    // Random loads and live blanking changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(0, 11) == 0) begin
        rd = 16'($urandom);
        nz = $urandom_range(0, 4);
        rd = rd & (16'hFFFF >> (4 * nz));
        do_load(rd, 4'($urandom));
      end else begin
        step();
      end
    end

    // Async reset mid-slot of digit 2, with a pending load that must be discarded.
    do_load(16'h9999, 4'b1111);
    align(2 * DIV + 4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", {28'd0, bus.an}, 32'hF);
    check("async_rst_seg", {25'd0, bus.seg}, 32'h0);
    check("async_rst_dp", {31'd0, bus.dp}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.lz_blank = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      step();
      if (bus.frame_done) fd_edges.push_back(e);
    end
    f0 = (fd_edges.size() > 0) ? fd_edges[0] : -1;
    f1 = (fd_edges.size() > 1) ? fd_edges[1] - fd_edges[0] : -1;
    check("first_frame_done_edge", f0, FRAME);
    check("frame_done_period", f1, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
